// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable 50%-duty clock divider with a tick enable.
// Optional macro CLK_DIV_CTRL_TICK_CNT_EN adds a 16-bit tick counter output.
module clk_div_ctrl #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEF_HALF = 127
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_half
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_half_q, pend_half_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic count_en;
  logic to_idle;
  logic wrap;
  logic fall;
  logic xfer;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    pend_half_d = pend_half_q;
    pend_vld_d  = pend_vld_q;
    clk_d       = clk_q;
    count_en    = 1'b0;
    to_idle     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (run) state_d = RUN;
      end
      RUN: begin
        count_en = 1'b1;
        if (!run) state_d = STOP;
      end
      STOP: begin
        if (run) begin
          state_d  = RUN;
          count_en = 1'b1;
        end else if (!clk_q) begin
          // low phase may be cut short; high phase never is
          state_d = IDLE;
          cnt_d   = '0;
          to_idle = 1'b1;
        end else begin
          count_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    wrap = count_en && (cnt_q == half_q);
    if (count_en) begin
      if (wrap) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    tick_d = wrap && !clk_q;
    fall   = wrap && clk_q;
    xfer   = cfg_valid && !pend_vld_q;

    if ((fall || to_idle) && pend_vld_q) begin
      half_d     = pend_half_q;
      pend_vld_d = 1'b0;
    end

    // xfer implies no pending value, so it never races the apply above
    if (xfer) begin
      if (state_q == IDLE) begin
        half_d = cfg_half;
      end else begin
        pend_half_d = cfg_half;
        pend_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      half_q      <= DIV_W'(DEF_HALF);
      pend_half_q <= '0;
      pend_vld_q  <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      pend_vld_q  <= pend_vld_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
    end
  end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_d) tick_cnt_d = tick_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt = tick_cnt_q;
`endif

  assign cfg_ready = ~pend_vld_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign busy      = (state_q != IDLE);
  assign cur_half  = half_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench for clk_div_ctrl.
// Reference model tracks position within the output period.
module tb_clk_div_ctrl;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_half = '0;
  logic         cfg_ready;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic [W-1:0] cur_half;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0]  tick_cnt;
`endif

  clk_div_ctrl #(.DIV_W(W), .DEF_HALF(127)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_half  (cur_half)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    ,
    .tick_cnt  (tick_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit clk;
    bit tk;
    bit bsy;
    bit rdy;
    int half;
    int tcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model: mode 0 idle, 1 running, 2 stopping
  int m_mode = 0;
  int m_pos  = 0;
  int m_h    = 127;
  int m_pend = 0;
  bit m_pv   = 0;
  bit m_tick = 0;
  bit m_xfer = 0;
  int m_tcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv,
               $time);
    end
  endtask

  task automatic apply_pend();
    if (m_pv) begin
      m_h  = m_pend;
      m_pv = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit rn, input bit cv,
                            input int ch);
    bit count;
    bit was_idle;
    m_tick = 0;
    m_xfer = 0;
    if (r) begin
      m_mode = 0;
      m_pos  = 0;
      m_h    = 127;
      m_pv   = 0;
      m_tcnt = 0;
      return;
    end
    count    = 0;
    was_idle = (m_mode == 0);
    m_xfer   = cv && !m_pv;
    case (m_mode)
      0: if (rn) begin
        m_mode = 1;
        m_pos  = 0;
      end
      1: begin
        count = 1;
        if (!rn) m_mode = 2;
      end
      default: begin
        if (rn) begin
          m_mode = 1;
          count  = 1;
        end else if (m_pos <= m_h) begin
          m_mode = 0;
          m_pos  = 0;
          apply_pend();
        end else begin
          count = 1;
        end
      end
    endcase
    if (count) begin
      m_pos++;
      if (m_pos == m_h + 1) m_tick = 1;
      if (m_pos == 2 * (m_h + 1)) begin
        m_pos = 0;
        apply_pend();
      end
    end
    if (m_xfer) begin
      if (was_idle) begin
        m_h = ch;
      end else begin
        m_pend = ch;
        m_pv   = 1;
      end
    end
    if (m_tick) m_tcnt = (m_tcnt + 1) % 65536;
  endtask

  task automatic cyc(input bit r, input bit rn, input bit cv, input int ch);
    logic [31:0] chv;
    exp_t e;
    chv = ch;
    @(negedge clk_in);
    rst       = r;
    run       = rn;
    cfg_valid = cv;
    cfg_half  = chv[W-1:0];
    model_step(r, rn, cv, ch);
    e.clk  = (m_mode != 0) && (m_pos > m_h);
    e.tk   = m_tick;
    e.bsy  = (m_mode != 0);
    e.rdy  = !m_pv;
    e.half = m_h;
    e.tcnt = m_tcnt;
    exp_q.push_back(e);
  endtask

  task automatic run_n(input int n, input bit rn);
    for (int i = 0; i < n; i++) cyc(0, rn, 0, 0);
  endtask

  task automatic until_pos(input int t, input bit rn);
    for (int i = 0; i < 2000; i++) begin
      if (m_mode != 0 && m_pos == t) break;
      cyc(0, rn, 0, 0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("clk_out", clk_out, e.clk);
        chk("tick", tick, e.tk);
        chk("busy", busy, e.bsy);
        chk("cfg_ready", cfg_ready, e.rdy);
        chk("cur_half", cur_half, e.half);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        chk("tick_cnt", tick_cnt, e.tcnt);
`endif
      end
    end
  end

  initial begin : stim
    bit acc;
    bit rn;
    bit cv;
    bit r;
    int ch;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    run_n(5, 0);
    run_n(600, 1);
    until_pos(127 + 10, 1);
    run_n(300, 0);
    cyc(0, 0, 1, 0);
    run_n(20, 1);
    run_n(4, 0);
    cyc(0, 0, 1, 127);
    run_n(200, 1);
    until_pos(127 + 60, 1);
    cyc(0, 1, 1, 3);
    acc = 0;
    for (int i = 0; i < 400 && !acc; i++) begin
      cyc(0, 1, 1, 5);
      acc = m_xfer;
    end
    run_n(100, 1);
    until_pos(1, 1);
    run_n(6, 0);
    cyc(0, 0, 1, 20);
    run_n(30, 1);
    until_pos(25, 1);
    run_n(3, 0);
    run_n(60, 1);
    until_pos(3, 1);
    cyc(0, 0, 0, 0);
    run_n(50, 1);
    until_pos(30, 1);
    cyc(0, 1, 1, 9);
    run_n(2, 1);
    cyc(1, 1, 0, 0);
    run_n(3, 0);
    rn = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) rn = !rn;
      cv = ($urandom_range(0, 9) == 0);
      ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 7));
      r  = ($urandom_range(0, 1499) == 0);
      cyc(r, rn, cv, ch);
    end
    @(posedge clk_in);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
